// File: rtl/sdram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_stream_reader
//  Purpose  : Sequential SDRAM read engine. On start it reads length_i
//             consecutive 16-bit words from base_addr_i through the host
//             interface of sdram_cntl. It keeps one read outstanding at a
//             time and buffers the words in a first-word-fall-through FIFO.
//             The FIFO drives a valid/ready stream.
//  Ports    : clk_i/rst_i           clock, synchronous active-high reset
//             start_i/base_addr_i/length_i/abort_i   transfer control
//             busy_o/done_o         transfer status
//             sdram_*               host interface of sdram_cntl
//             dout_o/dout_valid_o/dout_ready_i/fifo_level_o  output stream
//  Revision : 1.0  initial release
// ============================================================================
module sdram_stream_reader #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int LEN_W      = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [ADDR_W-1:0]             base_addr_i,
  input  logic [LEN_W-1:0]              length_i,
  input  logic                          abort_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          sdram_rd_o,
  output logic                          sdram_wr_o,
  output logic [ADDR_W-1:0]             sdram_addr_o,
  output logic [DATA_W-1:0]             sdram_wdata_o,
  input  logic                          sdram_done_i,
  input  logic [DATA_W-1:0]             sdram_rdata_i,
  input  logic                          sdram_rdpend_i,
  output logic [DATA_W-1:0]             dout_o,
  output logic                          dout_valid_o,
  input  logic                          dout_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DRAIN = 3'd4,
    S_ABORT = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                abort_pend_q, abort_pend_d;
  logic                done_q, done_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic rd;
  logic push;
  logic pop;
  logic flush;

  // Read-pending status from the controller is informational only.
  logic unused_rdpend;
  assign unused_rdpend = sdram_rdpend_i;

  // The FIFO is hidden during the flush cycle so that no word is handed out
  // after an abort has been accepted.
  assign dout_valid_o  = (level_q != '0) && (state_q != S_ABORT);
  assign pop           = dout_valid_o && dout_ready_i;
  assign dout_o        = dout_valid_o ? mem_q[rd_ptr_q] : '0;
  assign fifo_level_o  = level_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign sdram_rd_o    = rd;
  assign sdram_wr_o    = 1'b0;
  assign sdram_addr_o  = addr_q;
  assign sdram_wdata_o = '0;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    abort_pend_d = abort_pend_q;
    done_d       = 1'b0;
    rd           = 1'b0;
    push         = 1'b0;
    flush        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d = base_addr_i;
          rem_d  = length_i;
          if (length_i == '0) done_d  = 1'b1;
          else                state_d = S_REQ;
        end
      end
      S_REQ: begin
        // A read reserves a FIFO slot at issue. A pop in this same cycle
        // frees a slot, so a full FIFO with a pop may still issue.
        if (abort_i) begin
          state_d = S_ABORT;
        end else if ((level_q < LVL_W'(FIFO_DEPTH)) || pop) begin
          rd      = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        rd = 1'b1;
        if (sdram_done_i) begin
          if (abort_i || abort_pend_q) begin
            abort_pend_d = 1'b0;
            state_d      = S_ABORT;
          end else begin
            push    = 1'b1;
            addr_d  = addr_q + 1'b1;
            rem_d   = rem_q - 1'b1;
            state_d = S_GAP;
          end
        end else if (abort_i) begin
          // The controller cannot cancel a read, so rd stays high until it
          // completes. The word that arrives is then discarded.
          abort_pend_d = 1'b1;
        end
      end
      S_GAP: begin
        if (abort_i)           state_d = S_ABORT;
        else if (rem_q == '0)  state_d = S_DRAIN;
        else                   state_d = S_REQ;
      end
      S_DRAIN: begin
        if (abort_i) begin
          state_d = S_ABORT;
        end else if (level_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        flush   = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      abort_pend_q <= abort_pend_d;
      done_q       <= done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
    end
  end

  // Storage needs no reset because the level counter gates visibility.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= sdram_rdata_i;
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_stream_reader
//  Purpose  : Self-checking bench for sdram_stream_reader. It contains an
//             SDRAM responder with random latency and a random-ready
//             consumer. Expected address and data queues are built from
//             the transfer rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sdram_stream_reader;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 24;
  localparam int DEPTH  = 16;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [LEN_W-1:0]  length_i;
  logic              abort_i;
  logic              busy_o;
  logic              done_o;
  logic              sdram_rd_o;
  logic              sdram_wr_o;
  logic [ADDR_W-1:0] sdram_addr_o;
  logic [DATA_W-1:0] sdram_wdata_o;
  logic              sdram_done_i;
  logic [DATA_W-1:0] sdram_rdata_i;
  logic              sdram_rdpend_i;
  logic [DATA_W-1:0] dout_o;
  logic              dout_valid_o;
  logic              dout_ready_i;
  logic [4:0]        fifo_level_o;

  sdram_stream_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .length_i(length_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o),
    .sdram_rd_o(sdram_rd_o), .sdram_wr_o(sdram_wr_o),
    .sdram_addr_o(sdram_addr_o), .sdram_wdata_o(sdram_wdata_o),
    .sdram_done_i(sdram_done_i), .sdram_rdata_i(sdram_rdata_i),
    .sdram_rdpend_i(sdram_rdpend_i),
    .dout_o(dout_o), .dout_valid_o(dout_valid_o),
    .dout_ready_i(dout_ready_i), .fifo_level_o(fifo_level_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Contents of the simulated SDRAM: a fixed function of the word address.
  function automatic logic [15:0] data_fn(input logic [23:0] a);
    return (a[15:0] * 16'd3) ^ {a[23:16], 8'h5A};
  endfunction

  logic [23:0] exp_addr[$];
  logic [15:0] exp_q[$];
  logic [23:0] rd_addrs[$];
  int          done_cnt = 0;
  int          resp_cnt = 0;
  int          ready_mode = 1;
  int          extra_lat = 0;
  bit          rd_low_allowed = 0;

  // SDRAM responder. It samples on the falling edge and drives done for a
  // full clock period.
  initial begin : p_sdram
    bit          inflight = 0;
    bit          prev_done = 0;
    int          lat = 0;
    logic [23:0] cur_addr = '0;
    sdram_done_i   = 1'b0;
    sdram_rdata_i  = '0;
    sdram_rdpend_i = 1'b0;
    forever begin
      @(negedge clk_i);
      sdram_done_i = 1'b0;
      if (prev_done) check("rd_gap", sdram_rd_o, 1'b0);
      prev_done = 0;
      if (inflight && !sdram_rd_o) begin
        if (!rd_low_allowed) check("rd_held", 1'b0, 1'b1);
        inflight = 0;
      end else if (sdram_rd_o) begin
        if (!inflight) begin
          inflight = 1;
          cur_addr = sdram_addr_o;
          rd_addrs.push_back(cur_addr);
          lat = 1 + $urandom_range(0, 2) + extra_lat;
        end else begin
          check("addr_hold", sdram_addr_o, cur_addr);
        end
        if (lat == 0) begin
          sdram_done_i  = 1'b1;
          sdram_rdata_i = data_fn(cur_addr);
          inflight      = 0;
          prev_done     = 1;
          resp_cnt++;
        end else begin
          lat--;
        end
      end
      sdram_rdpend_i = inflight;
    end
  end

  // Consumer ready, driven just after the rising edge.
  initial begin : p_ready
    dout_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        0:       dout_ready_i = 1'b0;
        1:       dout_ready_i = 1'b1;
        default: dout_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Stream checker and done counter.
  initial begin : p_consume
    forever begin
      @(negedge clk_i);
      if (!rst_i) check("level_max", fifo_level_o <= 5'(DEPTH), 1'b1);
      if (done_o) done_cnt++;
      if (dout_valid_o && dout_ready_i) begin
        if (exp_q.size() == 0) check("extra_pop", 1'b1, 1'b0);
        else                   check("data", dout_o, exp_q.pop_front());
      end
    end
  end

  task automatic start_xfer(input logic [23:0] base, input logic [23:0] len);
    exp_q.delete();
    exp_addr.delete();
    rd_addrs.delete();
    done_cnt = 0;
    for (int i = 0; i < int'(len); i++) begin
      exp_addr.push_back(base + 24'(i));
      exp_q.push_back(data_fn(base + 24'(i)));
    end
    @(posedge clk_i); #1;
    start_i = 1'b1; base_addr_i = base; length_i = len;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    if (len != '0) begin
      check("first_rd", sdram_rd_o, 1'b1);
      check("first_addr", sdram_addr_o, base);
    end
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin
      @(negedge clk_i);
      n++;
    end
    check("done_seen", done_cnt != 0, 1'b1);
  endtask

  task automatic wait_reads(input int cnt, input int limit);
    int n = 0;
    while (rd_addrs.size() < cnt && n < limit) begin
      @(negedge clk_i);
      n++;
    end
    check("reads_reached", rd_addrs.size() >= cnt, 1'b1);
  endtask

  task automatic finish_checks(input int len);
    check("busy_low", busy_o, 1'b0);
    check("all_data", exp_q.size(), 0);
    check("n_reads", rd_addrs.size(), len);
    for (int i = 0; i < rd_addrs.size() && i < exp_addr.size(); i++)
      check("rd_addr", rd_addrs[i], exp_addr[i]);
    repeat (3) @(negedge clk_i);
    check("one_done", done_cnt, 1);
    check("level_zero", fifo_level_o, 0);
  endtask

  initial begin : p_main
    int r_before;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    base_addr_i = '0; length_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_rd", sdram_rd_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_valid", dout_valid_o, 1'b0);
    check("rst_level", fifo_level_o, 0);
    check("rst_addr", sdram_addr_o, 0);
    check("rst_wr", sdram_wr_o, 1'b0);
    check("rst_wdata", sdram_wdata_o, 0);
    check("rst_dout", dout_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Basic four-word transfer.
    ready_mode = 1; extra_lat = 0;
    start_xfer(24'h000010, 24'd4);
    wait_done(200);
    finish_checks(4);

    // Zero length: done on the next cycle, no read.
    rd_addrs.delete(); done_cnt = 0;
    @(posedge clk_i); #1;
    start_i = 1'b1; base_addr_i = 24'h000055; length_i = '0;
    @(negedge clk_i);
    check("len0_pre", done_o, 1'b0);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    check("len0_done", done_o, 1'b1);
    check("len0_busy", busy_o, 1'b0);
    @(negedge clk_i);
    check("len0_pulse", done_o, 1'b0);
    repeat (5) @(negedge clk_i);
    check("len0_reads", rd_addrs.size(), 0);

    // Address wraps at the top of the address space.
    start_xfer(24'hFFFFFE, 24'd4);
    wait_done(200);
    finish_checks(4);

    // Back-pressure: FIFO fills, reads stall, then resume.
    ready_mode = 0;
    start_xfer(24'h001000, 24'd20);
    wait_reads(16, 400);
    repeat (20) @(negedge clk_i);
    check("stall_reads", rd_addrs.size(), 16);
    check("stall_level", fifo_level_o, 16);
    check("stall_rd", sdram_rd_o, 1'b0);
    check("stall_busy", busy_o, 1'b1);
    check("stall_valid", dout_valid_o, 1'b1);
    ready_mode = 1;
    wait_done(600);
    finish_checks(20);

    // Abort while a read is in flight with a slow controller.
    extra_lat = 6;
    r_before = resp_cnt;
    start_xfer(24'h002000, 24'd8);
    wait_reads(2, 200);
    @(posedge clk_i); #1;
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    wait_done(100);
    check("abort_busy", busy_o, 1'b0);
    check("abort_level", fifo_level_o, 0);
    check("abort_valid", dout_valid_o, 1'b0);
    check("abort_resp", resp_cnt - r_before, 2);
    check("abort_dropped", exp_q.size(), 7);
    repeat (10) @(negedge clk_i);
    check("abort_reads", rd_addrs.size(), 2);
    check("abort_one_done", done_cnt, 1);
    exp_q.delete();

    // Reset during a read.
    start_xfer(24'h003000, 24'd4);
    @(posedge clk_i); #1;
    rd_low_allowed = 1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_rd_held", sdram_rd_o, 1'b1);
    @(negedge clk_i);
    check("mrst_rd", sdram_rd_o, 1'b0);
    check("mrst_busy", busy_o, 1'b0);
    check("mrst_done", done_o, 1'b0);
    check("mrst_valid", dout_valid_o, 1'b0);
    check("mrst_level", fifo_level_o, 0);
    check("mrst_addr", sdram_addr_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (6) @(negedge clk_i);
    check("mrst_reads", rd_addrs.size(), 1);
    check("mrst_nodone", done_cnt, 0);
    rd_low_allowed = 0;
    exp_q.delete();

    // Randomized transfers.
    for (int k = 0; k < 6; k++) begin
      logic [23:0] b;
      int          l;
      ready_mode = 2;
      extra_lat  = $urandom_range(0, 2);
      b = 24'($urandom);
      l = $urandom_range(1, 40);
      start_xfer(b, 24'(l));
      wait_done(l * 40 + 200);
      finish_checks(l);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
